// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake, one-entry output buffer and an
// iterative shift-add unsigned multiply. Define ALU_SAT_EN for saturating arithmetic.
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_aluop,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_alu_out,
  output logic              o_alu_isOverflow,
  output logic              o_alu_hasBranch,
  output logic              o_illegal
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADDU = 4'd2;
  localparam logic [3:0] OP_SUBU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SRL  = 4'd11;
  localparam logic [3:0] OP_SRA  = 4'd12;
  localparam logic [3:0] OP_MULU = 4'd13;

  localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONES_W   = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] SMAX_W   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN_W   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t state_r, next_state_s;

  logic              valid_r, ovf_r, br_r, ill_r;
  logic [DATA_W-1:0] out_r;

  logic [2*DATA_W-1:0] mcand_r, acc_r, acc_next_s;
  logic [DATA_W-1:0]   mplier_r;
  logic [CNT_W-1:0]    cnt_r;

  logic              accept_s, mul_start_s, mul_done_s;
  logic [DATA_W:0]   sum_s, diff_s;
  logic [SH_W-1:0]   shamt_s;
  logic [DATA_W-1:0] res_s;
  logic              ovf_s, br_s, ill_s;

  assign o_valid          = valid_r;
  assign o_alu_out        = out_r;
  assign o_alu_isOverflow = ovf_r;
  assign o_alu_hasBranch  = br_r;
  assign o_illegal        = ill_r;

  assign o_ready  = (state_r == IDLE) && (!valid_r || i_ready);
  assign accept_s = i_valid && o_ready;
  assign sum_s    = {1'b0, i_data1} + {1'b0, i_data2};
  assign diff_s   = {1'b0, i_data1} - {1'b0, i_data2};
  assign shamt_s  = i_data2[SH_W-1:0];
  assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {(2*DATA_W){1'b0}});

  // Single-cycle operation result and flags
  always_comb begin
    res_s = ZERO_W;
    ovf_s = 1'b0;
    br_s  = 1'b0;
    ill_s = 1'b0;
    case (i_aluop)
      OP_ADD: begin
        ovf_s = (i_data1[MSB] == i_data2[MSB]) && (sum_s[MSB] != i_data1[MSB]);
`ifdef ALU_SAT_EN
        if (ovf_s) begin
          res_s = i_data1[MSB] ? SMIN_W : SMAX_W;
        end else begin
          res_s = sum_s[DATA_W-1:0];
        end
`else
        res_s = sum_s[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        ovf_s = (i_data1[MSB] != i_data2[MSB]) && (diff_s[MSB] != i_data1[MSB]);
`ifdef ALU_SAT_EN
        if (ovf_s) begin
          res_s = i_data1[MSB] ? SMIN_W : SMAX_W;
        end else begin
          res_s = diff_s[DATA_W-1:0];
        end
`else
        res_s = diff_s[DATA_W-1:0];
`endif
      end
      OP_ADDU: begin
        ovf_s = sum_s[DATA_W];
`ifdef ALU_SAT_EN
        res_s = ovf_s ? ONES_W : sum_s[DATA_W-1:0];
`else
        res_s = sum_s[DATA_W-1:0];
`endif
      end
      OP_SUBU: begin
        // Bit DATA_W of the zero-extended difference is the borrow (A < B)
        ovf_s = diff_s[DATA_W];
`ifdef ALU_SAT_EN
        res_s = ovf_s ? ZERO_W : diff_s[DATA_W-1:0];
`else
        res_s = diff_s[DATA_W-1:0];
`endif
      end
      OP_AND:  res_s = i_data1 & i_data2;
      OP_OR:   res_s = i_data1 | i_data2;
      OP_NOR:  res_s = ~(i_data1 | i_data2);
      OP_BEQ:  br_s  = (i_data1 == i_data2);
      OP_BNE:  br_s  = (i_data1 != i_data2);
      OP_SLT:  res_s = ($signed(i_data1) < $signed(i_data2)) ? ONE_W : ZERO_W;
      OP_SLL:  res_s = i_data1 << shamt_s;
      OP_SRL:  res_s = i_data1 >> shamt_s;
      OP_SRA:  res_s = $signed(i_data1) >>> shamt_s;
      OP_MULU: res_s = ZERO_W;
      default: ill_s = 1'b1;
    endcase
  end

  // FSM next-state and multiply start/finish strobes
  always_comb begin
    next_state_s = state_r;
    mul_start_s  = 1'b0;
    mul_done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (i_aluop == OP_MULU)) begin
          next_state_s = MUL;
          mul_start_s  = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = IDLE;
          mul_done_s   = 1'b1;
        end else begin
          next_state_s = MUL;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Shift-add multiplier: one multiplier bit consumed per cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mcand_r  <= {(2*DATA_W){1'b0}};
      mplier_r <= ZERO_W;
      acc_r    <= {(2*DATA_W){1'b0}};
      cnt_r    <= CNT_ZERO;
    end else if (mul_start_s) begin
      mcand_r  <= {ZERO_W, i_data1};
      mplier_r <= i_data2;
      acc_r    <= {(2*DATA_W){1'b0}};
      cnt_r    <= CNT_ZERO;
    end else if (state_r == MUL) begin
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      acc_r    <= acc_next_s;
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

  // Output buffer: load a new result, or drop the current one once accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_r <= 1'b0;
      out_r   <= ZERO_W;
      ovf_r   <= 1'b0;
      br_r    <= 1'b0;
      ill_r   <= 1'b0;
    end else if (mul_done_s) begin
      valid_r <= 1'b1;
      out_r   <= acc_next_s[DATA_W-1:0];
      ovf_r   <= |acc_next_s[2*DATA_W-1:DATA_W];
      br_r    <= 1'b0;
      ill_r   <= 1'b0;
    end else if (accept_s && (i_aluop != OP_MULU)) begin
      valid_r <= 1'b1;
      out_r   <= res_s;
      ovf_r   <= ovf_s;
      br_r    <= br_s;
      ill_r   <= ill_s;
    end else if (i_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (DATA_W=32): directed vectors push expected
// results; a negedge monitor pops and compares on every output handshake.
module tb_alu_pipe;

  logic        i_clk, i_rst, i_valid, o_ready, o_valid, i_ready;
  logic [3:0]  i_aluop;
  logic [31:0] i_data1, i_data2, o_alu_out;
  logic        o_alu_isOverflow, o_alu_hasBranch, o_illegal;

  typedef struct packed {
    logic [31:0] out;
    logic        ovf;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_pipe #(.DATA_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_aluop(i_aluop), .i_data1(i_data1), .i_data2(i_data2),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu_out(o_alu_out),
    .o_alu_isOverflow(o_alu_isOverflow), .o_alu_hasBranch(o_alu_hasBranch),
    .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected entry
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out", o_alu_out, e.out);
        check("ovf", {31'd0, o_alu_isOverflow}, {31'd0, e.ovf});
        check("branch", {31'd0, o_alu_hasBranch}, {31'd0, e.br});
        check("illegal", {31'd0, o_illegal}, {31'd0, e.ill});
      end
    end
  end

  // Present a request, wait (bounded) for acceptance; returns #1 after the accept edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic eovf, input logic ebr,
                       input logic eill, input bit push);
    int n;
    exp_t e;
    i_valid = 1'b1;
    i_aluop = op;
    i_data1 = a;
    i_data2 = b;
    n = 0;
    while (!o_ready && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'd1, 32'd0);
    e.out = eo; e.ovf = eovf; e.br = ebr; e.ill = eill;
    if (push) exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    i_valid = 1'b0;
    repeat (cycles) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    int n;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_aluop = 4'd0; i_data1 = 32'd0; i_data2 = 32'd0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_out", o_alu_out, 32'd0);
    check("rst_flags", {29'd0, o_alu_isOverflow, o_alu_hasBranch, o_illegal}, 32'd0);
    i_rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    idle(1);

    // Signed add overflow, registered one cycle after accept
`ifdef ALU_SAT_EN
    issue(4'd0, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("add_latency_out", o_alu_out, 32'h7FFFFFFF);
`else
    issue(4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1);
    check("add_latency_out", o_alu_out, 32'h80000000);
`endif
    check("add_latency_valid", {31'd0, o_valid}, 32'd1);
    idle(2);

    // Back-to-back SUBU then SLT
`ifdef ALU_SAT_EN
    issue(4'd3, 32'd3, 32'd5, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    issue(4'd3, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    check("b2b_valid0", {31'd0, o_valid}, 32'd1);
    issue(4'd9, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b_valid1", {31'd0, o_valid}, 32'd1);

    // Assorted single-cycle ops streamed back-to-back
    issue(4'd0, 32'hFFFFFFFB, 32'd3, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_SAT_EN
    issue(4'd1, 32'h80000000, 32'd1, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    issue(4'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    issue(4'd1, 32'd10, 32'd4, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd4, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd5, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd6, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd8, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(4'd7, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd9, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd10, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd11, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd12, 32'h80000000, 32'd35, 32'hF0000000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd14, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(4'd15, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // BEQ held in the output buffer while downstream stalls
    i_ready = 1'b0;
    issue(4'd7, 32'd7, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", {31'd0, o_valid}, 32'd1);
      check("stall_ready", {31'd0, o_ready}, 32'd0);
      check("stall_branch", {31'd0, o_alu_hasBranch}, 32'd1);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    idle(2);

    // Multiply: busy for DATA_W cycles, then result
    issue(4'd13, 32'h00010000, 32'h00010000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    i_valid = 1'b0;
    n = 0;
    while (!o_ready && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("mul_busy_cycles", n, 32'd32);
    check("mul_done_valid", {31'd0, o_valid}, 32'd1);
    issue(4'd13, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'd13, 32'd0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd13, 32'd65535, 32'd65537, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    i_valid = 1'b0;
    idle(40);

    // Reset at cycle 10 of a multiply: aborted, nothing emitted
    issue(4'd13, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    i_valid = 1'b0;
    idle(9);
    i_rst = 1'b1;
    #1;
    check("abort_valid", {31'd0, o_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, o_ready}, 32'd1);
    idle(40);

    // A plain op after the abort still works
    issue(4'd2, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
